// File: rtl/rf_multiport_sb.sv
// Multi-read-port integer register file with hardwired zero register,
// optional write-to-read bypass and per-register pending-write scoreboard.
module rf_multiport_sb #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1,
    parameter int CNT_W    = 2,
    parameter int DBG_REG  = 20
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic [NUM_RD*ADDR_W-1:0] ReadReg,
    output logic [NUM_RD*DATA_W-1:0] ReadData,
    output logic [NUM_RD-1:0]        Busy,
    input  logic [ADDR_W-1:0]        WriteReg,
    input  logic [DATA_W-1:0]        WriteData,
    input  logic                     RegWrite,
    input  logic                     IssueValid,
    input  logic [ADDR_W-1:0]        IssueReg,
    output logic                     IssueReady,
    output logic [DATA_W-1:0]        DbgData
);

    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZR      = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] DR      = ADDR_W'(DBG_REG);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_cnt [DEPTH];

    logic w_wr_en;
    logic w_issue;
    logic w_retire;
    logic w_same;

    // Writes to the zero register never reach storage or the scoreboard.
    assign w_wr_en    = RegWrite && (WriteReg != ZR);
    assign IssueReady = (IssueReg == ZR) || (r_cnt[IssueReg] != CNT_MAX);
    assign w_issue    = IssueValid && IssueReady && (IssueReg != ZR);
    assign w_retire   = w_wr_en && (r_cnt[WriteReg] != '0);
    assign w_same     = w_issue && w_retire && (IssueReg == WriteReg);
    assign DbgData    = (DR == ZR) ? '0 : r_mem[DR];

    // Register storage: cleared on reset, one write port from writeback.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[WriteReg] <= WriteData;
        end
    end

    // Pending-write counters: issue increments, retire decrements,
    // both on the same register cancel out.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (!w_same) begin
            if (w_issue) begin
                r_cnt[IssueReg] <= r_cnt[IssueReg] + CNT_ONE;
            end
            if (w_retire) begin
                r_cnt[WriteReg] <= r_cnt[WriteReg] - CNT_ONE;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_hit;
        logic              w_last;

        assign w_ra   = ReadReg[p*ADDR_W +: ADDR_W];
        // Same-cycle writeback to this source, forwarded when bypass is built.
        assign w_hit  = (BYPASS != 0) && w_wr_en && (WriteReg == w_ra);
        // The retiring write is the last one outstanding for this source.
        assign w_last = w_hit && (r_cnt[w_ra] == CNT_ONE);

        assign ReadData[p*DATA_W +: DATA_W] =
            (w_ra == ZR) ? '0 :
            w_hit        ? WriteData :
                           r_mem[w_ra];

        assign Busy[p] = (w_ra != ZR) && (r_cnt[w_ra] != '0) && !w_last;
    end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Self-checking bench for rf_multiport_sb: directed vector table,
// reset corner cases and randomized run against a behavioural model.
module tb_rf_multiport_sb;

    logic         clk = 1'b0;
    logic         Reset;
    logic [9:0]   rr;
    logic [127:0] rd_a, rd_b;
    logic [1:0]   busy_a, busy_b;
    logic [4:0]   wa;
    logic [63:0]  wd;
    logic         we;
    logic         iv;
    logic [4:0]   ir;
    logic         rdy_a, rdy_b;
    logic [63:0]  dbg_a, dbg_b;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rf_multiport_sb u_byp (
        .clk(clk), .Reset(Reset), .ReadReg(rr), .ReadData(rd_a),
        .Busy(busy_a), .WriteReg(wa), .WriteData(wd), .RegWrite(we),
        .IssueValid(iv), .IssueReg(ir), .IssueReady(rdy_a),
        .DbgData(dbg_a)
    );

    rf_multiport_sb #(.BYPASS(0)) u_nob (
        .clk(clk), .Reset(Reset), .ReadReg(rr), .ReadData(rd_b),
        .Busy(busy_b), .WriteReg(wa), .WriteData(wd), .RegWrite(we),
        .IssueValid(iv), .IssueReg(ir), .IssueReady(rdy_b),
        .DbgData(dbg_b)
    );

    // Behavioural model: register contents and outstanding-write counts.
    logic [63:0] m_mem [32];
    int          m_cnt [32];

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = '0;
            m_cnt[i] = 0;
        end
    endtask

    function automatic logic [63:0] m_read(int a, bit byp);
        if (a == 31) return '0;
        if (byp && we && int'(wa) == a) return wd;
        return m_mem[a];
    endfunction

    function automatic bit m_busy(int a, bit byp);
        if (a == 31 || m_cnt[a] == 0) return 1'b0;
        if (byp && we && int'(wa) == a && m_cnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_ready();
        return (ir == 5'd31) || (m_cnt[ir] < 3);
    endfunction

    task automatic m_step();
        bit iss, ret;
        iss = iv && m_ready() && ir != 5'd31;
        ret = we && wa != 5'd31 && m_cnt[wa] > 0;
        if (we && wa != 5'd31) m_mem[wa] = wd;
        if (iss) m_cnt[ir] = m_cnt[ir] + 1;
        if (ret) m_cnt[wa] = m_cnt[wa] - 1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic w, input logic [4:0] a,
                          input logic [63:0] d, input logic i,
                          input logic [4:0] r, input logic [4:0] r0,
                          input logic [4:0] r1);
        we = w; wa = a; wd = d; iv = i; ir = r;
        rr = {r1, r0};
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        iv;
        logic [4:0]  ir;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] e_rd0;
        logic [63:0] e_rd1;
        logic [1:0]  e_busy;
        logic        e_rdy;
        logic [63:0] e_dbg;
        logic [63:0] e_nrd0;
        logic        e_nbusy0;
    } vec_t;

    localparam logic [63:0] D1 = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;

    vec_t tbl [24];

    int pick [8];

    function automatic logic [4:0] rnd_reg();
        if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
        return 5'(pick[$urandom_range(0, 7)]);
    endfunction

    initial begin
        pick = '{1, 3, 7, 9, 20, 31, 7, 9};
        //          we wa  wd     iv ir  r0  r1 | rd0  rd1  busy  rdy dbg  nrd0 nb0
        tbl[0]  = '{0, 0,  0,     0, 0,  5,  0,   0,   0,   2'b00, 1, 0,   0,   0};
        tbl[1]  = '{1, 1,  D1,    0, 0,  1,  2,   D1,  0,   2'b00, 1, 0,   0,   0};
        tbl[2]  = '{1, 2,  2,     0, 0,  1,  2,   D1,  2,   2'b00, 1, 0,   D1,  0};
        tbl[3]  = '{1, 20, 'h14,  0, 0,  1,  2,   D1,  2,   2'b00, 1, 0,   D1,  0};
        tbl[4]  = '{0, 0,  0,     0, 0,  20, 2,   'h14,2,   2'b00, 1, 'h14,'h14,0};
        tbl[5]  = '{1, 31, FF,    1, 31, 31, 31,  0,   0,   2'b00, 1, 'h14,0,   0};
        tbl[6]  = '{0, 0,  0,     1, 31, 31, 31,  0,   0,   2'b00, 1, 'h14,0,   0};
        tbl[7]  = '{1, 3,  5,     0, 0,  3,  3,   5,   5,   2'b00, 1, 'h14,0,   0};
        tbl[8]  = '{1, 3,  'h99,  0, 0,  3,  3,   'h99,'h99,2'b00, 1, 'h14,5,   0};
        tbl[9]  = '{0, 0,  0,     1, 7,  3,  1,   'h99,D1,  2'b00, 1, 'h14,'h99,0};
        tbl[10] = '{0, 0,  0,     1, 7,  7,  3,   0,   'h99,2'b01, 1, 'h14,0,   1};
        tbl[11] = '{0, 0,  0,     1, 7,  7,  3,   0,   'h99,2'b01, 1, 'h14,0,   1};
        tbl[12] = '{0, 0,  0,     1, 7,  7,  3,   0,   'h99,2'b01, 0, 'h14,0,   1};
        tbl[13] = '{1, 7,  'h70,  0, 7,  7,  3,   'h70,'h99,2'b01, 0, 'h14,0,   1};
        tbl[14] = '{1, 7,  'h71,  0, 7,  7,  3,   'h71,'h99,2'b01, 1, 'h14,'h70,1};
        tbl[15] = '{1, 7,  'h77,  0, 7,  7,  3,   'h77,'h99,2'b00, 1, 'h14,'h71,1};
        tbl[16] = '{0, 0,  0,     0, 7,  7,  3,   'h77,'h99,2'b00, 1, 'h14,'h77,0};
        tbl[17] = '{1, 8,  8,     0, 0,  8,  7,   8,   'h77,2'b00, 1, 'h14,0,   0};
        tbl[18] = '{0, 0,  0,     1, 8,  8,  7,   8,   'h77,2'b00, 1, 'h14,8,   0};
        tbl[19] = '{0, 0,  0,     1, 9,  9,  8,   0,   8,   2'b10, 1, 'h14,0,   0};
        tbl[20] = '{1, 9,  9,     1, 9,  9,  8,   9,   8,   2'b10, 1, 'h14,0,   1};
        tbl[21] = '{0, 0,  0,     0, 9,  9,  8,   9,   8,   2'b11, 1, 'h14,9,   1};
        tbl[22] = '{1, 8,  'h88,  1, 10, 10, 8,   0,   'h88,2'b00, 1, 'h14,0,   0};
        tbl[23] = '{0, 0,  0,     0, 10, 10, 8,   0,   'h88,2'b01, 1, 'h14,0,   1};

        // Power-on reset held for two cycles, X5 read while in reset.
        Reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 5, 0);
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_rd0", rd_a[63:0], 0);
        chk("rst_rd1", rd_a[127:64], 0);
        chk("rst_busy", 64'(busy_a), 0);
        chk("rst_rdy", 64'(rdy_a), 1);
        chk("rst_dbg", dbg_a, 0);
        Reset = 1'b1;
        #1;
        chk("post_rst_x5", rd_a[63:0], 0);

        for (int k = 0; k < 24; k++) begin
            set_in(tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].iv, tbl[k].ir,
                   tbl[k].ra0, tbl[k].ra1);
            #1;
            chk($sformatf("v%0d_rd0", k), rd_a[63:0], tbl[k].e_rd0);
            chk($sformatf("v%0d_rd1", k), rd_a[127:64], tbl[k].e_rd1);
            chk($sformatf("v%0d_busy", k), 64'(busy_a), 64'(tbl[k].e_busy));
            chk($sformatf("v%0d_rdy", k), 64'(rdy_a), 64'(tbl[k].e_rdy));
            chk($sformatf("v%0d_dbg", k), dbg_a, tbl[k].e_dbg);
            chk($sformatf("v%0d_nb_rd0", k), rd_b[63:0], tbl[k].e_nrd0);
            chk($sformatf("v%0d_nb_busy0", k), 64'(busy_b[0]),
                64'(tbl[k].e_nbusy0));
            tick();
        end

        // Reset mid-cycle with X10 pending and a write to X9 in flight.
        set_in(1, 9, 64'hAA, 1, 9, 10, 9);
        #1;
        chk("pre_rst_busy10", 64'(busy_a[0]), 1);
        Reset = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy_a), 0);
        chk("mid_rst_rd0", rd_a[63:0], 0);
        chk("mid_rst_rdy", 64'(rdy_a), 1);
        chk("mid_rst_dbg", dbg_a, 0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        Reset = 1'b1;
        set_in(0, 0, 0, 0, 9, 9, 20);
        #1;
        chk("after_rst_x9", rd_a[63:0], 0);
        chk("after_rst_x20", rd_a[127:64], 0);
        chk("after_rst_busy", 64'(busy_a), 0);
        tick();

        // Randomized traffic against the model, both bypass variants.
        for (int k = 0; k < 600; k++) begin
            set_in(1'($urandom_range(0, 1)), rnd_reg(), {$urandom, $urandom},
                   1'($urandom_range(0, 1)), rnd_reg(), rnd_reg(), rnd_reg());
            #1;
            for (int p = 0; p < 2; p++) begin
                int a;
                a = int'(rr[p*5 +: 5]);
                chk($sformatf("r%0d_rd%0d", k, p), rd_a[p*64 +: 64],
                    m_read(a, 1));
                chk($sformatf("r%0d_busy%0d", k, p), 64'(busy_a[p]),
                    64'(m_busy(a, 1)));
                chk($sformatf("r%0d_nb_rd%0d", k, p), rd_b[p*64 +: 64],
                    m_read(a, 0));
                chk($sformatf("r%0d_nb_busy%0d", k, p), 64'(busy_b[p]),
                    64'(m_busy(a, 0)));
            end
            chk($sformatf("r%0d_rdy", k), 64'(rdy_a), 64'(m_ready()));
            chk($sformatf("r%0d_nb_rdy", k), 64'(rdy_b), 64'(m_ready()));
            chk($sformatf("r%0d_dbg", k), dbg_a, m_mem[20]);
            chk($sformatf("r%0d_nb_dbg", k), dbg_b, m_mem[20]);
            if ($urandom_range(0, 99) == 0) begin
                Reset = 1'b0;
                #1;
                chk($sformatf("r%0d_rst_busy", k), 64'(busy_a), 0);
                m_reset();
                @(posedge clk);
                @(negedge clk);
                Reset = 1'b1;
            end else begin
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_multiport_sb.md
Name: rf_multiport_sb

Overview:
- Parametrised successor to the pipeline's 2-read/1-write 64-bit integer register file.
- Provides NUM_RD combinational read ports and a hardwired zero register.
- Adds optional write-to-read bypass and a per-register pending-write scoreboard, so the decode stage can detect RAW hazards without an external hazard table.
- Includes a parametrised debug tap register.
- Sits between the decode stage (reads, issue marking) and writeback (writes, retire).

Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 31, index hardwired to zero (XZR)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads
- CNT_W, 2, width of each per-register pending counter
- DBG_REG, 20, register index driven on DbgData

Ports:
- clk  in  1  clock; all state changes on the rising edge
- Reset  in  1  asynchronous, active-low reset
- ReadReg  in  NUM_RD*ADDR_W  packed read indices; port i = bits [i*ADDR_W +: ADDR_W]
- ReadData  out  NUM_RD*DATA_W  packed read data, same slicing scheme
- Busy  out  NUM_RD  per read port: source register still has an outstanding write
- WriteReg  in  ADDR_W  writeback destination index
- WriteData  in  DATA_W  writeback data
- RegWrite  in  1  writeback enable; also retires one pending write
- IssueValid  in  1  decode issues an instruction that writes IssueReg
- IssueReg  in  ADDR_W  destination of the issued instruction
- IssueReady  out  1  IssueReg counter is not saturated; issue is accepted
- DbgData  out  DATA_W  live contents of register DBG_REG

Behaviour:
- Storage: 2**ADDR_W words of DATA_W flops plus 2**ADDR_W counters of CNT_W bits.
- Reset low: all words and all counters clear to 0 asynchronously. Outputs settle to ReadData=0, Busy=0, IssueReady=1, DbgData=0. Reset asserted mid-operation discards in-flight writes and issues in that cycle.
- Write: on the rising edge with RegWrite=1 and WriteReg!=ZERO_REG, word[WriteReg] <= WriteData. Writes to ZERO_REG are ignored.
- Read: combinational.
  - ReadReg_i==ZERO_REG -> 0, regardless of writes.
  - BYPASS=1, RegWrite=1, WriteReg==ReadReg_i != ZERO_REG -> WriteData (same cycle).
  - Otherwise -> word[ReadReg_i].
  - BYPASS=0 -> the stored word only; new data is visible the cycle after the write.
- Scoreboard, counter c[r], updated on the rising edge:
  - Issue accepted = IssueValid & IssueReady & IssueReg!=ZERO_REG.
  - Retire = RegWrite & WriteReg!=ZERO_REG & c[WriteReg]!=0.
  - Issue only -> c+1.
  - Retire only -> c-1.
  - Issue and retire on the same register in the same cycle -> c unchanged.
  - Issue and retire on different registers -> both updates apply.
  - RegWrite to a register with c=0 writes data and leaves c at 0; no underflow.
- IssueReady = (IssueReg==ZERO_REG) | (c[IssueReg] != 2**CNT_W-1). Combinational.
  - IssueValid with IssueReady=0 leaves c unchanged. The caller must stall decode.
- Busy_i = (ReadReg_i!=ZERO_REG) & (c[ReadReg_i]!=0), except:
  - With BYPASS=1, Busy_i=0 when RegWrite & WriteReg==ReadReg_i & c[ReadReg_i]==1, since the last pending write retires this cycle and its data is forwarded.
  - With BYPASS=0 that exception does not apply.
- DbgData = word[DBG_REG], combinational, no bypass. It is 0 if DBG_REG==ZERO_REG.
- Read ports are independent; all NUM_RD ports may address the same register.

Test Plan:
- Reset: drive Reset=0 for 2 cycles, then release -> all ReadData=0, Busy=0, IssueReady=1, DbgData=0. Read of X5 returns 0.
- Write/read: write X1=64'hDEAD_BEEF_0000_0001 and X2=64'h2; next cycle read ports 0/1 = X1/X2 -> 64'hDEAD_BEEF_0000_0001 / 64'h2. Write X20=64'h14 -> DbgData=64'h14 on the following cycle.
- Zero register: write X31=64'hFFFF_FFFF_FFFF_FFFF, then read X31 on all ports -> 0. IssueValid with IssueReg=31 -> IssueReady=1, Busy on X31 stays 0.
- Bypass: X3=5 stored; in the same cycle RegWrite X3=64'h99 with ReadReg0=3 -> ReadData0=64'h99 that cycle (BYPASS=1). Rebuild with BYPASS=0 -> ReadData0=5 that cycle, 64'h99 the next.
- Scoreboard: issue X7 three times (CNT_W=2) -> IssueReady=0 for X7; a 4th issue is dropped. Busy on X7 stays 1 through two retires. On the 3rd retire with ReadReg0=7, Busy0=0 in the retire cycle and ReadData0=WriteData.
- Simultaneous events and reset: issue+retire X9 in the same cycle with c=1 -> c stays 1, Busy stays 1. Assert Reset mid-sequence with X9 pending -> Busy=0 immediately, X9 reads 0.
